// File: rtl/adpcm_pkg.sv
`default_nettype none
// ============================================================================
// Package : adpcm_pkg
// Shared widths, header length and FSM encoding for the ADPCM stream sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package adpcm_pkg;

    localparam int PCM_W   = 16;
    localparam int CODE_W  = 4;
    localparam int IDX_W   = 7;
    localparam int HDR_LEN = 3;

    typedef enum logic [2:0] {
        RX_LO    = 3'd0,
        RX_HI    = 3'd1,
        HDR0     = 3'd2,
        HDR1     = 3'd3,
        HDR2     = 3'd4,
        ENC_WAIT = 3'd5,
        EMIT     = 3'd6
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/adpcm_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module : adpcm_stream_sequencer
// Assembles PCM samples, drives the ADPCM encoder, packs codes and frames blocks.
// Rev    : 1.0  initial release
// ============================================================================
module adpcm_stream_sequencer
    import adpcm_pkg::*;
#(
    parameter int BLOCK_LEN = 64,
    parameter bit HDR_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [PCM_W-1:0]  enc_sample,
    output logic              enc_start,
    input  logic              enc_done,
    input  logic [CODE_W-1:0] enc_code,
    input  logic [PCM_W-1:0]  enc_pred,
    input  logic [IDX_W-1:0]  enc_index,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              block_start,
    output logic              busy
);

    localparam int               CNT_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

    seq_state_e                  state_q, state_d;
    logic [7:0]                  lo_q, lo_d;
    logic [PCM_W-1:0]            sample_q, sample_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        half_q, half_d;
    logic [CODE_W-1:0]           nib_q, nib_d;
    logic [HDR_LEN-1:0][7:0]     hdr_q, hdr_d;
    logic [7:0]                  emit_q, emit_d;
    logic                        start_q, start_d;
    logic                        bstart_q, bstart_d;
    logic                        flush_pend_q, flush_pend_d;
    logic                        flush_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RX_LO;
            lo_q         <= '0;
            sample_q     <= '0;
            cnt_q        <= '0;
            half_q       <= 1'b0;
            nib_q        <= '0;
            hdr_q        <= '0;
            emit_q       <= '0;
            start_q      <= 1'b0;
            bstart_q     <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            sample_q     <= sample_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            nib_q        <= nib_d;
            hdr_q        <= hdr_d;
            emit_q       <= emit_d;
            start_q      <= start_d;
            bstart_q     <= bstart_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign flush_act = flush | flush_pend_q;

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        sample_d     = sample_q;
        cnt_d        = cnt_q;
        half_d       = half_q;
        nib_d        = nib_q;
        hdr_d        = hdr_q;
        emit_d       = emit_q;
        start_d      = 1'b0;
        bstart_d     = 1'b0;
        flush_pend_d = flush_pend_q | flush;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_byte     = 8'h00;

        case (state_q)
            RX_LO: begin
                // A flush leaving a half-filled byte blocks input while it is emitted.
                in_ready = !(flush_act && half_q);
                if (flush_act) begin
                    flush_pend_d = 1'b0;
                    cnt_d        = '0;
                    if (half_q) begin
                        emit_d  = {4'h0, nib_q};
                        half_d  = 1'b0;
                        state_d = EMIT;
                    end
                end
                if (in_valid && in_ready) begin
                    lo_d    = in_byte;
                    state_d = RX_HI;
                end
            end

            RX_HI: begin
                if (flush) begin
                    state_d = RX_LO;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        sample_d = {in_byte, lo_q};
                        bstart_d = (cnt_q == '0);
                        if (HDR_EN && (cnt_q == '0)) begin
                            hdr_d[0] = enc_pred[7:0];
                            hdr_d[1] = enc_pred[15:8];
                            hdr_d[2] = {1'b0, enc_index};
                            state_d  = HDR0;
                        end else begin
                            start_d = 1'b1;
                            state_d = ENC_WAIT;
                        end
                    end
                end
            end

            HDR0: begin
                out_valid = 1'b1;
                out_byte  = hdr_q[0];
                if (out_ready) begin
                    state_d = HDR1;
                end
            end

            HDR1: begin
                out_valid = 1'b1;
                out_byte  = hdr_q[1];
                if (out_ready) begin
                    state_d = HDR2;
                end
            end

            HDR2: begin
                out_valid = 1'b1;
                out_byte  = hdr_q[2];
                if (out_ready) begin
                    start_d = 1'b1;
                    state_d = ENC_WAIT;
                end
            end

            ENC_WAIT: begin
                // start_q marks the first cycle, where enc_done is ignored.
                if (!start_q && enc_done) begin
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                    if (!half_q) begin
                        nib_d   = enc_code;
                        half_d  = 1'b1;
                        state_d = RX_LO;
                    end else begin
                        emit_d  = {enc_code, nib_q};
                        half_d  = 1'b0;
                        state_d = EMIT;
                    end
                end
            end

            EMIT: begin
                out_valid = 1'b1;
                out_byte  = emit_q;
                if (out_ready) begin
                    state_d = RX_LO;
                end
            end

            default: begin
                state_d = RX_LO;
            end
        endcase
    end

    assign enc_sample  = sample_q;
    assign enc_start   = start_q;
    assign block_start = bstart_q;
    assign busy        = (state_q != RX_LO) || half_q;

endmodule

`default_nettype wire

// File: tb/tb_adpcm_stream_sequencer.sv
`default_nettype none
// Testbench for adpcm_stream_sequencer: directed and random traffic checked
// against a byte-stream reference model and a behavioural encoder.
module tb_adpcm_stream_sequencer;

    localparam int BLOCK_LEN = 4;
    localparam bit HDR_EN    = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] enc_sample;
    logic        enc_start;
    logic        enc_done;
    logic [3:0]  enc_code;
    logic [15:0] enc_pred;
    logic [6:0]  enc_index;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        block_start;
    logic        busy;

    always #5 clk = ~clk;

    adpcm_stream_sequencer #(
        .BLOCK_LEN (BLOCK_LEN),
        .HDR_EN    (HDR_EN)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .enc_sample  (enc_sample),
        .enc_start   (enc_start),
        .enc_done    (enc_done),
        .enc_code    (enc_code),
        .enc_pred    (enc_pred),
        .enc_index   (enc_index),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .block_start (block_start),
        .busy        (busy)
    );

    int errs   = 0;
    int checks = 0;

    int ready_mode = 1;   // 0 random, 1 always, 2 never, 3 driven by the main sequence
    int lat_mode   = 1;   // 0 random 1..20, 1 fixed 1, 2 fixed 20
    bit mon_en     = 1'b1;
    bit enc_busy   = 1'b0;

    logic [7:0]  exp_q[$];
    logic [15:0] smp_q[$];
    int n_out_exp = 0, n_out_seen = 0, n_smp_exp = 0, n_start = 0;
    int exp_blk = 0, blk_seen = 0;

    int          m_cnt  = 0;
    bit          m_half = 1'b0;
    logic [3:0]  m_nib  = 4'h0;
    logic [15:0] m_pred = 16'h1234;
    logic [6:0]  m_idx  = 7'd5;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input logic [15:0] s);
        return (s[3:0] + s[15:12]) ^ s[9:6];
    endfunction

    function automatic logic [15:0] pred_next(input logic [15:0] p, input logic [15:0] s,
                                              input logic [3:0] c);
        return (p ^ s) + {12'h0, c};
    endfunction

    function automatic logic [6:0] idx_next(input logic [6:0] i, input logic [3:0] c);
        return 7'((int'(i) + int'(c)) % 89);
    endfunction

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
        n_out_exp++;
    endtask

    task automatic model_sample(input logic [15:0] s);
        logic [3:0] c;
        if (m_cnt == 0) begin
            exp_blk++;
            if (HDR_EN) begin
                push_exp(m_pred[7:0]);
                push_exp(m_pred[15:8]);
                push_exp({1'b0, m_idx});
            end
        end
        c      = code_of(s);
        m_pred = pred_next(m_pred, s, c);
        m_idx  = idx_next(m_idx, c);
        if (!m_half) begin
            m_nib  = c;
            m_half = 1'b1;
        end else begin
            push_exp({c, m_nib});
            m_half = 1'b0;
        end
        m_cnt = (m_cnt + 1) % BLOCK_LEN;
        smp_q.push_back(s);
        n_smp_exp++;
    endtask

    task automatic model_flush();
        if (m_half) push_exp({4'h0, m_nib});
        m_half = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("in_accept_timeout", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic raw_send(input logic [15:0] s, input bit push);
        if (push) begin
            smp_q.push_back(s);
            n_smp_exp++;
        end
        send_byte(s[7:0]);
        send_byte(s[15:8]);
    endtask

    task automatic send_sample(input logic [15:0] s);
        model_sample(s);
        raw_send(s, 1'b0);
    endtask

    task automatic flush_pulse();
        model_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || enc_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        chk("idle_busy", busy, m_half);
        chk("idle_out_valid", out_valid, 0);
    endtask

    // Output monitor and out_ready driver
    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                2:       out_ready = 1'b0;
                default: ;
            endcase
            if (block_start) blk_seen++;
            if (mon_en && out_valid && out_ready) begin
                n_out_seen++;
                if (exp_q.size() > 0) chk("out_byte", out_byte, exp_q.pop_front());
            end
        end
    end

    // Behavioural encoder with configurable latency
    initial begin
        logic [15:0] smp;
        logic [3:0]  c;
        bit          ab;
        int          lat;
        enc_done  = 1'b0;
        enc_code  = 4'h0;
        enc_pred  = 16'h1234;
        enc_index = 7'd5;
        forever begin
            @(negedge clk);
            if (enc_start) begin
                enc_busy = 1'b1;
                smp      = enc_sample;
                ab       = 1'b0;
                n_start++;
                if (smp_q.size() > 0) chk("enc_sample", smp, smp_q.pop_front());
                lat = (lat_mode == 1) ? 1 : (lat_mode == 2) ? 20 : int'($urandom_range(1, 20));
                repeat (lat) begin
                    @(posedge clk);
                    if (rst) ab = 1'b1;
                    @(negedge clk);
                end
                if (!ab) chk("enc_hold", enc_sample, smp);
                c        = code_of(smp);
                enc_done = 1'b1;
                enc_code = c;
                @(posedge clk);
                @(negedge clk);
                enc_done  = 1'b0;
                enc_pred  = pred_next(enc_pred, smp, c);
                enc_index = idx_next(enc_index, c);
                enc_busy  = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        int bad_hold, bad_inr, bad_st;
        logic [7:0]  v0;
        logic [15:0] s;
        in_byte  = 8'h00;
        in_valid = 1'b0;
        flush    = 1'b0;
        out_ready = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_enc_start", enc_start, 0);
        chk("rst_block_start", block_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enc_sample", enc_sample, 0);
        chk("rst_out_byte", out_byte, 0);

        // Two samples of the first block, header from 1234/5
        ready_mode = 1;
        lat_mode   = 1;
        send_sample(16'hA1B2);
        send_sample(16'h0C3D);
        drain();
        chk("t1_block_start", blk_seen, 1);

        // Output stall in EMIT
        send_sample(16'h5E6F);
        ready_mode = 2;
        send_sample(16'h7788);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached", out_valid, 1);
        chk("stall_front", out_byte, exp_q[0]);
        v0 = out_byte;
        bad_hold = 0; bad_inr = 0; bad_st = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || out_byte != v0) bad_hold++;
            if (in_ready) bad_inr++;
            if (enc_start) bad_st++;
        end
        chk("stall_hold", bad_hold, 0);
        chk("stall_in_ready", bad_inr, 0);
        chk("stall_enc_start", bad_st, 0);
        ready_mode = 0;

        // Block wrap: next sample opens a new block
        send_sample(16'h1111);
        send_sample(16'h2222);
        send_sample(16'h3333);
        drain();

        // Flush with a half byte, redundant flush, then a new block
        flush_pulse();
        send_sample(16'hBEEF);
        flush_pulse();
        flush_pulse();
        send_sample(16'hCAFE);
        send_sample(16'hF00D);
        drain();

        // Encoder latency 1 then 20 on the same data
        for (int k = 0; k < 2; k++) begin
            lat_mode = (k == 0) ? 1 : 2;
            flush_pulse();
            send_sample(16'h0102);
            send_sample(16'h0304);
            send_sample(16'h0506);
            send_sample(16'h0708);
            drain();
        end

        // Reset while in HDR1, then while in ENC_WAIT
        flush_pulse();
        drain();
        mon_en     = 1'b0;
        ready_mode = 3;
        out_ready  = 1'b0;
        lat_mode   = 2;
        raw_send(16'h4242, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_hdr0_reached", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t6_hdr1_byte", out_byte, m_pred[15:8]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6a_out_valid", out_valid, 0);
        chk("t6a_busy", busy, 0);
        chk("t6a_in_ready", in_ready, 1);
        raw_send(16'h1357, 1'b1);
        out_ready = 1'b1;
        n = 0;
        while (!enc_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        chk("t6_enc_start_seen", enc_start, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6b_out_valid", out_valid, 0);
        chk("t6b_busy", busy, 0);
        chk("t6b_in_ready", in_ready, 1);
        n = 0;
        while (enc_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        m_pred  = enc_pred;
        m_idx   = enc_index;
        m_cnt   = 0;
        m_half  = 1'b0;
        exp_blk += 2;
        mon_en     = 1'b1;
        ready_mode = 0;
        lat_mode   = 0;
        send_sample(16'h2468);
        send_sample(16'h9BDF);
        drain();

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 99));
            s = 16'($urandom());
            if (r < 80) begin
                send_sample(s);
            end else if (r < 92) begin
                flush_pulse();
            end else begin
                send_byte(s[7:0]);
                flush_pulse();
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        chk("out_count", n_out_seen, n_out_exp);
        chk("enc_start_count", n_start, n_smp_exp);
        chk("block_start_count", blk_seen, exp_blk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
